// File: rtl/sirv_gnrl_rr_arb_stage_if.sv
`timescale 1ns/1ps
// sirv_gnrl_rr_arb_stage_if
// Bundles the N requester channels and the single downstream channel of the
// round-robin arbitration stage.
//   i_vld  [N]     per-requester valid          (requester -> stage)
//   i_rdy  [N]     per-requester ready          (stage -> requester)
//   i_dat  [N*DW]  requester k data at [k*DW +: DW]
//   i_last [N]     requester k beat ends its burst
//   o_vld          stage holds a beat           (stage -> downstream)
//   o_rdy          downstream ready             (downstream -> stage)
//   o_dat  [DW]    registered data
//   o_id   [IW]    index of the requester that supplied o_dat
//   o_last         registered i_last of that beat
// The slave modport is the arbitration stage itself; the master modport is
// the environment that sources requests and sinks the output.
interface sirv_gnrl_rr_arb_stage_if #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int IW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]    i_vld;
  logic [N-1:0]    i_rdy;
  logic [N*DW-1:0] i_dat;
  logic [N-1:0]    i_last;
  logic            o_vld;
  logic            o_rdy;
  logic [DW-1:0]   o_dat;
  logic [IW-1:0]   o_id;
  logic            o_last;

  modport slave (
    input  i_vld, i_dat, i_last, o_rdy,
    output i_rdy, o_vld, o_dat, o_id, o_last
  );

  modport master (
    output i_vld, i_dat, i_last, o_rdy,
    input  i_rdy, o_vld, o_dat, o_id, o_last
  );
endinterface

// File: rtl/sirv_gnrl_rr_arb_stage.sv
`timescale 1ns/1ps
// sirv_gnrl_rr_arb_stage
// One registered valid/ready pipe stage shared by N requesters. A round-robin
// pointer picks the next requester; with ALLOW_LOCK=1 a requester that sends a
// non-last beat keeps exclusive ownership of the stage until its last beat.
// The winning beat is registered together with the requester index.
// Ports:
//   clk  clock, all state on the rising edge
//   rst  asynchronous reset, active-high; discards any held beat and lock
//   bus  sirv_gnrl_rr_arb_stage_if.slave (requester side and output side)
// Parameters:
//   N, DW       requester count and data width
//   CUT_READY   1: accept only when empty (no o_rdy -> i_rdy path)
//   ALLOW_LOCK  1: hold the grant across a burst until i_last
module sirv_gnrl_rr_arb_stage #(
  parameter int N          = 4,
  parameter int DW         = 32,
  parameter int CUT_READY  = 0,
  parameter int ALLOW_LOCK = 1
) (
  input logic                     clk,
  input logic                     rst,
  sirv_gnrl_rr_arb_stage_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          vld_q, vld_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [IW-1:0] id_q, id_d;
  logic          last_q, last_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          lock_q, lock_d;
  logic [IW-1:0] lock_id_q, lock_id_d;

  logic          stage_rdy;
  logic          pop;
  logic          acc;
  logic          found;
  logic [N-1:0]  gnt;
  logic [IW-1:0] win_id;
  logic [IW-1:0] sel_id;
  int            sel_idx;
  logic [DW-1:0] win_dat;
  logic          win_last;

  assign pop       = vld_q & bus.o_rdy;
  assign stage_rdy = (CUT_READY != 0) ? ~vld_q : (~vld_q | pop);

  // Grant selection. While locked only the owner may be granted, even when it
  // is idle, so no other requester can slip a beat into the middle of a burst.
  // Otherwise scan from the pointer upward with wrap-around.
  always_comb begin
    gnt     = '0;
    win_id  = '0;
    found   = 1'b0;
    sel_idx = 0;
    sel_id  = '0;
    if (lock_q) begin
      gnt[lock_id_q] = bus.i_vld[lock_id_q];
      win_id         = lock_id_q;
    end else begin
      for (int i = 0; i < N; i++) begin
        sel_idx = int'(ptr_q) + i;
        if (sel_idx >= N) sel_idx = sel_idx - N;
        sel_id = IW'(sel_idx);
        if (!found && bus.i_vld[sel_id]) begin
          found       = 1'b1;
          gnt[sel_id] = 1'b1;
          win_id      = sel_id;
        end
      end
    end
  end

  // The grant is one-hot or zero, so an OR-style mux picks the winner's beat.
  always_comb begin
    win_dat  = '0;
    win_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (gnt[k]) begin
        win_dat  = bus.i_dat[k*DW +: DW];
        win_last = bus.i_last[k];
      end
    end
  end

  assign acc = stage_rdy & (|gnt);

  // Next-state: an accept always loads the stage (covering pop+accept in the
  // same cycle); a pop without an accept empties it. The pointer only moves
  // past a requester once its burst is complete.
  always_comb begin
    vld_d     = vld_q;
    dat_d     = dat_q;
    id_d      = id_q;
    last_d    = last_q;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (acc) begin
      vld_d  = 1'b1;
      dat_d  = win_dat;
      id_d   = win_id;
      last_d = win_last;
      if (win_last || (ALLOW_LOCK == 0)) begin
        ptr_d = (win_id == IW'(N - 1)) ? '0 : win_id + IW'(1);
      end
      if (ALLOW_LOCK != 0) begin
        lock_d = ~win_last;
        if (!win_last) lock_id_d = win_id;
      end
    end else if (pop) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= 1'b0;
      dat_q     <= '0;
      id_q      <= '0;
      last_q    <= 1'b0;
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      vld_q     <= vld_d;
      dat_q     <= dat_d;
      id_q      <= id_d;
      last_q    <= last_d;
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  assign bus.i_rdy  = stage_rdy ? gnt : '0;
  assign bus.o_vld  = vld_q;
  assign bus.o_dat  = dat_q;
  assign bus.o_id   = id_q;
  assign bus.o_last = last_q;

endmodule

// File: tb/tb_sirv_gnrl_rr_arb_stage.sv
`timescale 1ns/1ps
// Testbench for sirv_gnrl_rr_arb_stage. Two instances: the default
// configuration (CUT_READY=0, ALLOW_LOCK=1) and a CUT_READY=1, ALLOW_LOCK=0
// variant. Per-requester beat queues source the inputs; expected output beats
// are queued by the directed tests and popped by an independent monitor.
module tb_sirv_gnrl_rr_arb_stage;
  localparam int N  = 4;
  localparam int DW = 32;

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] dat;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sirv_gnrl_rr_arb_stage_if #(.N(N), .DW(DW)) bus0 ();
  sirv_gnrl_rr_arb_stage_if #(.N(N), .DW(DW)) bus1 ();

  sirv_gnrl_rr_arb_stage #(.N(N), .DW(DW), .CUT_READY(0), .ALLOW_LOCK(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  sirv_gnrl_rr_arb_stage #(.N(N), .DW(DW), .CUT_READY(1), .ALLOW_LOCK(0)) dut_cut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  beat_t        srcQ[N][$];
  exp_t         expQ0[$];
  exp_t         expQ1[$];
  logic [N-1:0] en;
  logic         oRdy;
  int           sel;
  logic [N-1:0] lastHs;
  int           nTotal;
  int           nBad;
  exp_t         monE0;
  exp_t         monE1;

  function automatic logic [31:0] mk(input int t, input int k, input int b);
    return {8'hD0, t[7:0], k[7:0], b[7:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    nTotal++;
    if (act !== req) begin
      nBad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic addBeat(input int k, input logic [31:0] dat, input logic last);
    beat_t b;
    b.dat  = dat;
    b.last = last;
    srcQ[k].push_back(b);
  endtask

  task automatic expectBeat(input logic [1:0] id, input logic [31:0] dat, input logic last);
    exp_t e;
    e.id   = id;
    e.dat  = dat;
    e.last = last;
    if (sel == 0) expQ0.push_back(e);
    else expQ1.push_back(e);
  endtask

  // Present the head of every enabled, non-empty source queue to the selected
  // instance; the other instance sees idle inputs.
  task automatic drive();
    logic [N-1:0]    v;
    logic [N*DW-1:0] d;
    logic [N-1:0]    l;
    beat_t           b;
    v = '0;
    d = '0;
    l = '0;
    for (int k = 0; k < N; k++) begin
      if (en[k] && srcQ[k].size() != 0) begin
        b = srcQ[k][0];
        v[k] = 1'b1;
        d[k*DW +: DW] = b.dat;
        l[k] = b.last;
      end
    end
    if (sel == 0) begin
      bus0.i_vld = v;  bus0.i_dat = d;  bus0.i_last = l;  bus0.o_rdy = oRdy;
      bus1.i_vld = '0; bus1.i_dat = '0; bus1.i_last = '0; bus1.o_rdy = 1'b0;
    end else begin
      bus1.i_vld = v;  bus1.i_dat = d;  bus1.i_last = l;  bus1.o_rdy = oRdy;
      bus0.i_vld = '0; bus0.i_dat = '0; bus0.i_last = '0; bus0.o_rdy = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] enMask, input logic rdy);
    en   = enMask;
    oRdy = rdy;
    drive();
    #1;
  endtask

  // One clock: note which requesters handshake, let the edge happen, retire
  // the accepted beats and present the next ones. Returns at posedge+2.
  task automatic step();
    beat_t tmp;
    @(negedge clk);
    lastHs = (sel == 0) ? (bus0.i_vld & bus0.i_rdy) : (bus1.i_vld & bus1.i_rdy);
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (lastHs[k]) tmp = srcQ[k].pop_front();
    end
    drive();
    #1;
  endtask

  // Monitor: every output transfer is matched against the next queued beat;
  // grants must never be more than one-hot.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("onehot0", 64'($countones(bus0.i_rdy) <= 1), 64'd1);
      checkOutput("onehot1", 64'($countones(bus1.i_rdy) <= 1), 64'd1);
      if (bus0.o_vld && bus0.o_rdy) begin
        if (expQ0.size() == 0) begin
          nTotal++;
          nBad++;
          $display("[TB] FAIL beat0: got id=%0d dat=%0h, want no beat", bus0.o_id, bus0.o_dat);
        end else begin
          monE0 = expQ0.pop_front();
          checkOutput("beat0", {bus0.o_id, bus0.o_dat, bus0.o_last}, monE0);
        end
      end
      if (bus1.o_vld && bus1.o_rdy) begin
        if (expQ1.size() == 0) begin
          nTotal++;
          nBad++;
          $display("[TB] FAIL beat1: got id=%0d dat=%0h, want no beat", bus1.o_id, bus1.o_dat);
        end else begin
          monE1 = expQ1.pop_front();
          checkOutput("beat1", {bus1.o_id, bus1.o_dat, bus1.o_last}, monE1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nTotal = 0;
    nBad   = 0;
    sel    = 0;
    en     = '0;
    oRdy   = 1'b0;
    lastHs = '0;
    rst    = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_o_vld", bus0.o_vld, 0);
    checkOutput("rst_o_dat", bus0.o_dat, 0);
    checkOutput("rst_o_id", bus0.o_id, 0);
    checkOutput("rst_o_last", bus0.o_last, 0);
    checkOutput("rst_i_rdy", bus0.i_rdy, 0);
    checkOutput("rst_o_vld_cut", bus1.o_vld, 0);
    rst = 1'b0;
    #1;

    // Round robin from reset: all four requesters with single-beat bursts.
    for (int k = 0; k < N; k++) addBeat(k, mk(1, k, 0), 1'b1);
    addBeat(0, mk(1, 0, 1), 1'b1);
    addBeat(1, mk(1, 1, 1), 1'b1);
    for (int k = 0; k < N; k++) expectBeat(2'(k), mk(1, k, 0), 1'b1);
    expectBeat(2'd0, mk(1, 0, 1), 1'b1);
    expectBeat(2'd1, mk(1, 1, 1), 1'b1);
    applyStimulus(4'b1111, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step();
      checkOutput("rr_o_vld", bus0.o_vld, 1);
    end
    step();

    // Burst lock: requester 1 owns the stage for three beats, idling mid-burst.
    addBeat(1, mk(2, 1, 0), 1'b0);
    addBeat(1, mk(2, 1, 1), 1'b0);
    addBeat(1, mk(2, 1, 2), 1'b1);
    addBeat(0, mk(2, 0, 0), 1'b1);
    addBeat(2, mk(2, 2, 0), 1'b1);
    expectBeat(2'd1, mk(2, 1, 0), 1'b0);
    expectBeat(2'd1, mk(2, 1, 1), 1'b0);
    expectBeat(2'd1, mk(2, 1, 2), 1'b1);
    expectBeat(2'd2, mk(2, 2, 0), 1'b1);
    expectBeat(2'd0, mk(2, 0, 0), 1'b1);
    applyStimulus(4'b0010, 1'b1);
    step();
    applyStimulus(4'b0111, 1'b1);
    step();
    applyStimulus(4'b0101, 1'b1);
    for (int c = 0; c < 2; c++) begin
      checkOutput("lock_idle_rdy", bus0.i_rdy, 0);
      step();
    end
    applyStimulus(4'b0111, 1'b1);
    checkOutput("lock_resume_rdy", bus0.i_rdy, 4'b0010);
    repeat (4) step();

    // Backpressure on a full stage, then pop and accept in the same cycle.
    addBeat(2, mk(3, 2, 0), 1'b1);
    addBeat(2, mk(3, 2, 1), 1'b1);
    expectBeat(2'd2, mk(3, 2, 0), 1'b1);
    expectBeat(2'd2, mk(3, 2, 1), 1'b1);
    applyStimulus(4'b0100, 1'b0);
    step();
    for (int c = 0; c < 5; c++) begin
      step();
      checkOutput("bp_i_rdy", bus0.i_rdy, 0);
      checkOutput("bp_o_dat", bus0.o_dat, mk(3, 2, 0));
      checkOutput("bp_o_id", bus0.o_id, 2);
    end
    applyStimulus(4'b0100, 1'b1);
    checkOutput("bp_release_rdy", bus0.i_rdy, 4'b0100);
    step();
    checkOutput("bp_o_vld_held", bus0.o_vld, 1);
    checkOutput("bp_o_dat_new", bus0.o_dat, mk(3, 2, 1));
    step();

    // Reset in the middle of a burst with the stage full.
    addBeat(3, mk(4, 3, 0), 1'b0);
    applyStimulus(4'b1000, 1'b0);
    step();
    checkOutput("rstmid_full", bus0.o_vld, 1);
    rst = 1'b1;
    #1;
    checkOutput("rstmid_o_vld", bus0.o_vld, 0);
    rst = 1'b0;
    addBeat(0, mk(5, 0, 0), 1'b1);
    addBeat(3, mk(5, 3, 0), 1'b1);
    expectBeat(2'd0, mk(5, 0, 0), 1'b1);
    expectBeat(2'd3, mk(5, 3, 0), 1'b1);
    applyStimulus(4'b1001, 1'b1);
    checkOutput("rstmid_grant", bus0.i_rdy, 4'b0001);
    step();
    step();

    // Sparse traffic alternating between requesters 3 and 0 across the wrap.
    applyStimulus(4'b1111, 1'b1);
    for (int c = 0; c < 4; c++) begin
      if (c % 2 == 0) begin
        addBeat(3, mk(6, 3, c), 1'b1);
        expectBeat(2'd3, mk(6, 3, c), 1'b1);
      end else begin
        addBeat(0, mk(6, 0, c), 1'b1);
        expectBeat(2'd0, mk(6, 0, c), 1'b1);
      end
      drive();
      #1;
      step();
      checkOutput("wrap_hs", lastHs, (c % 2 == 0) ? 4'b1000 : 4'b0001);
    end
    step();

    // CUT_READY=1, ALLOW_LOCK=0: i_last ignored for arbitration and one beat
    // every two cycles under continuous traffic.
    sel = 1;
    addBeat(1, mk(7, 1, 0), 1'b0);
    addBeat(1, mk(7, 1, 1), 1'b0);
    addBeat(1, mk(7, 1, 2), 1'b1);
    addBeat(0, mk(7, 0, 0), 1'b1);
    addBeat(0, mk(7, 0, 1), 1'b1);
    addBeat(2, mk(7, 2, 0), 1'b1);
    addBeat(2, mk(7, 2, 1), 1'b1);
    expectBeat(2'd1, mk(7, 1, 0), 1'b0);
    expectBeat(2'd2, mk(7, 2, 0), 1'b1);
    expectBeat(2'd0, mk(7, 0, 0), 1'b1);
    expectBeat(2'd1, mk(7, 1, 1), 1'b0);
    expectBeat(2'd2, mk(7, 2, 1), 1'b1);
    expectBeat(2'd0, mk(7, 0, 1), 1'b1);
    expectBeat(2'd1, mk(7, 1, 2), 1'b1);
    applyStimulus(4'b0010, 1'b1);
    step();
    checkOutput("cut_hs_first", 64'(|lastHs), 1);
    applyStimulus(4'b0111, 1'b1);
    for (int c = 2; c <= 13; c++) begin
      step();
      checkOutput("cut_hs", 64'(|lastHs), 64'(c % 2));
    end

    for (int i = 0; i < 20 && (expQ0.size() != 0 || expQ1.size() != 0); i++) step();
    checkOutput("drain", 64'(expQ0.size() + expQ1.size()), 0);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
